// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, FSM states,
// control-field codes and the packed control vector.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_JAL    = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic       jal_flag;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_ADDI) || (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Combinational control decode: state (+ mem_ready in FETCH/MEMWR, Opcode in
// DECODE) to the full control vector. Holds no state.
module multicycle_output_decode
  import mips_pkg::*;
(
  input  state_t      state,
  input  logic        mem_ready,
  input  logic [5:0]  opcode,
  output ctrl_t       ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // IR/PC update only on the cycle the fetch actually completes
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_IMMSH2;
        ctrl.illegal_op = !op_known(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.jal_flag   = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: Moore FSM with memory-ready stalls. The state
// register is the only flop; all outputs decode combinationally.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       JALFlag,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_t state, state_nxt;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_RST:    state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        unique case (Opcode)
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_J:         state_nxt = S_JUMP;
          OP_JAL:       state_nxt = S_JAL;
          default:      state_nxt = S_FETCH;
        endcase
      end
      // IR is frozen after FETCH, so Opcode is still the decoded LW/SW here
      S_MEMADR: state_nxt = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_nxt = S_FETCH;
      S_EXEC:   state_nxt = S_ALUWB;
      S_ADDIEX: state_nxt = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB, S_JAL:
                state_nxt = S_FETCH;
      default:  state_nxt = S_RST;
    endcase
  end

  multicycle_output_decode u_dec (
    .state     (state),
    .mem_ready (mem_ready),
    .opcode    (Opcode),
    .ctrl      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IRWrite     = ctrl.ir_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign RegDst      = ctrl.reg_dst;
  assign RegWrite    = ctrl.reg_write;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign JALFlag     = ctrl.jal_flag;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign ALUOp       = ctrl.alu_op;
  assign PCSource    = ctrl.pc_source;
  assign instr_done  = ctrl.instr_done;
  assign illegal_op  = ctrl.illegal_op;
  assign state_dbg   = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-level reference model builds the
// expected state walk per instruction; control values come from a state table.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, JALFlag;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op;
  logic [3:0] state_dbg;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                         BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010,
                         JAL = 6'b000011;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt, ill_cnt, first_done;
  int cyc_in_instr;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .JALFlag(JALFlag), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  logic [18:0] dut_vec;
  assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, JALFlag,
                    ALUSrcB, ALUOp, PCSource, instr_done, illegal_op};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {RT, LW, SW, BEQ, ADDI, J, JAL};
  endfunction

  // Control table straight from the per-state signal list
  function automatic logic [18:0] exp_vec(input int st, input bit mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jf, dn, il;
    logic [1:0] srcb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jf, dn, il} = '0;
    {srcb, aop, pcs} = '0;
    case (st)
      1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      2:  begin srcb = 2'b11; il = !is_legal(op); end
      3:  begin asa = 1; srcb = 2'b10; end
      4:  begin mrd = 1; iord = 1; end
      5:  begin rw = 1; m2r = 1; dn = 1; end
      6:  begin mwr = 1; iord = 1; dn = mr; end
      7:  begin asa = 1; aop = 2'b10; end
      8:  begin rw = 1; rdst = 1; dn = 1; end
      9:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; dn = 1; end
      10: begin pcw = 1; pcs = 2'b10; dn = 1; end
      11: begin asa = 1; srcb = 2'b10; end
      12: begin rw = 1; dn = 1; end
      13: begin rw = 1; jf = 1; pcw = 1; pcs = 2'b10; dn = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, jf, srcb, aop, pcs, dn, il};
  endfunction

  // One clock: advance, drive inputs, check at the falling edge
  task automatic step(input int st, input bit mr, input logic [5:0] op);
    @(posedge clk);
    #1;
    Opcode    = op;
    mem_ready = mr;
    @(negedge clk);
    cyc_in_instr++;
    chk("state", 32'(state_dbg), 32'(st));
    chk("ctrl", 32'(dut_vec), 32'(exp_vec(st, mr, op)));
    if (instr_done) begin
      done_cnt++;
      if (first_done == 0) first_done = cyc_in_instr;
    end
    if (illegal_op) ill_cnt++;
  endtask

  // Reference walk for one instruction, with wf fetch waits and wm memory waits
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    int  sq[$];
    bit  mq[$];
    int  lat;
    repeat (wf) begin sq.push_back(1); mq.push_back(0); end
    sq.push_back(1); mq.push_back(1);
    sq.push_back(2); mq.push_back(1'($urandom));
    case (op)
      LW: begin
        sq.push_back(3); mq.push_back(1'($urandom));
        repeat (wm) begin sq.push_back(4); mq.push_back(0); end
        sq.push_back(4); mq.push_back(1);
        sq.push_back(5); mq.push_back(1'($urandom));
      end
      SW: begin
        sq.push_back(3); mq.push_back(1'($urandom));
        repeat (wm) begin sq.push_back(6); mq.push_back(0); end
        sq.push_back(6); mq.push_back(1);
      end
      RT:   begin sq.push_back(7);  mq.push_back(1'($urandom));
                  sq.push_back(8);  mq.push_back(1'($urandom)); end
      ADDI: begin sq.push_back(11); mq.push_back(1'($urandom));
                  sq.push_back(12); mq.push_back(1'($urandom)); end
      BEQ:  begin sq.push_back(9);  mq.push_back(1'($urandom)); end
      J:    begin sq.push_back(10); mq.push_back(1'($urandom)); end
      JAL:  begin sq.push_back(13); mq.push_back(1'($urandom)); end
      default: ;
    endcase
    case (op)
      LW:                lat = 5 + wf + wm;
      SW:                lat = 4 + wf + wm;
      RT, ADDI:          lat = 4 + wf;
      BEQ, J, JAL:       lat = 3 + wf;
      default:           lat = 0;
    endcase
    done_cnt = 0; ill_cnt = 0; first_done = 0; cyc_in_instr = 0;
    foreach (sq[i]) step(sq[i], mq[i], op);
    if (is_legal(op)) begin
      chk("done_count", 32'(done_cnt), 32'd1);
      chk("latency", 32'(first_done), 32'(lat));
      chk("no_illegal", 32'(ill_cnt), 32'd0);
    end else begin
      chk("illegal_count", 32'(ill_cnt), 32'd1);
      chk("illegal_no_done", 32'(done_cnt), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] legal_ops[7];
    logic [5:0] op;
    legal_ops = '{RT, LW, SW, BEQ, ADDI, J, JAL};
    rst_n = 1'b0; Opcode = 6'd0; mem_ready = 1'b1;

    // Reset held for 3 cycles: everything low, RST state, even with mem_ready high
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_ctrl", 32'(dut_vec), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_released_still_rst", 32'(state_dbg), 32'd0);

    run_instr(LW, 0, 0);
    run_instr(SW, 0, 3);
    run_instr(BEQ, 0, 0);
    run_instr(JAL, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(RT, 2, 0);
    run_instr(ADDI, 0, 0);
    run_instr(J, 1, 0);

    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 7) == 7) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = legal_ops[$urandom_range(0, 6)];
      end
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // Reset while MEMRD waits: request must drop without a clock edge
    done_cnt = 0; ill_cnt = 0; first_done = 0; cyc_in_instr = 0;
    step(1, 1, LW);
    step(2, 0, LW);
    step(3, 0, LW);
    step(4, 0, LW);
    step(4, 0, LW);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_memread", 32'(MemRead), 32'd0);
    chk("async_rst_state", 32'(state_dbg), 32'd0);
    chk("async_rst_ctrl", 32'(dut_vec), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_state", 32'(state_dbg), 32'd0);
    rst_n = 1'b1;
    run_instr(LW, 1, 1);
    run_instr(SW, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
